// File: rtl/alarm_kp_pkg.sv
// Shared key encodings, FSM state type and counter-width helper for the alarm keypad front-end.
// NEWCODE state exists only when KEYPAD_CODE_CHANGE_EN is defined.
package alarm_kp_pkg;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;
  localparam logic [3:0] KEY_SET   = 4'hC;

  typedef enum logic [2:0] {
    StIdle,
    StEntry,
    StCheck,
    StLockout
`ifdef KEYPAD_CODE_CHANGE_EN
    , StNewcode
`endif
  } state_e;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/kp_timer.sv
// Loadable down-counter: load wins over enable, counting stops at zero, expired flags zero.
module kp_timer #(
  parameter int unsigned Width = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_expired
);

  logic [Width-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/alarm_keypad_ctrl.sv
// Keypad code-entry controller issuing arm/disarm pulses with failed-attempt lockout.
// Define KEYPAD_CODE_CHANGE_EN to allow changing the stored code via SET.
module alarm_keypad_ctrl
  import alarm_kp_pkg::*;
#(
  parameter int unsigned CODE_LEN       = 4,
  parameter logic [31:0] DEFAULT_CODE   = 32'h0000_1234,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1000,
  parameter int unsigned ENTRY_TIMEOUT  = 500
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             key_valid,
  input  logic [3:0]                       key_code,
  input  logic                             armed_in,
  output logic                             cmd_arm,
  output logic                             cmd_disarm,
  output logic                             bad_code,
  output logic                             lockout,
  output logic                             entry_busy,
  output logic [cnt_width(CODE_LEN)-1:0]   digit_count
);

  localparam int unsigned BufW  = 4 * CODE_LEN;
  localparam int unsigned CntW  = cnt_width(CODE_LEN);
  localparam int unsigned FailW = cnt_width(MAX_FAILS);
  localparam int unsigned TMax  = (LOCKOUT_CYCLES > ENTRY_TIMEOUT) ? LOCKOUT_CYCLES : ENTRY_TIMEOUT;
  localparam int unsigned TmrW  = cnt_width(TMax);

  localparam logic [CntW-1:0]  LenCnt   = CntW'(CODE_LEN);
  localparam logic [FailW-1:0] FailMax  = FailW'(MAX_FAILS);
  // Timer is loaded with N-1 so the N-th cycle sees it expired.
  localparam logic [TmrW-1:0]  TmrEntry = TmrW'(ENTRY_TIMEOUT - 1);
  localparam logic [TmrW-1:0]  TmrLock  = TmrW'(LOCKOUT_CYCLES - 1);

  state_e            r_state, w_state_d;
  logic [BufW-1:0]   r_buf, w_buf_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic              r_ovf, w_ovf_d;
  logic [FailW-1:0]  r_fail, w_fail_d;
  logic              r_arm, w_arm_d;
  logic              r_disarm, w_disarm_d;
  logic              r_bad, w_bad_d;

  logic              w_tmr_load, w_tmr_en, w_tmr_expired;
  logic [TmrW-1:0]   w_tmr_val;

  logic              w_digit, w_enter, w_clear, w_set;
  logic              w_match, w_in_newcode, w_set_attempt;
  logic [BufW+3:0]   w_buf_sh;
  logic [BufW-1:0]   w_code;
  logic [FailW-1:0]  w_fail_inc;

  assign w_digit    = key_valid && (key_code <= 4'h9);
  assign w_enter    = key_valid && (key_code == KEY_ENTER);
  assign w_clear    = key_valid && (key_code == KEY_CLEAR);
  assign w_buf_sh   = {r_buf, key_code};
  assign w_fail_inc = r_fail + 1'b1;
  assign w_match    = (r_cnt == LenCnt) && !r_ovf && (r_buf == w_code);

`ifdef KEYPAD_CODE_CHANGE_EN
  logic [BufW-1:0] r_code, w_code_d;
  logic            r_chk_set, w_chk_set_d;

  assign w_set         = key_valid && (key_code == KEY_SET);
  assign w_in_newcode  = (r_state == StNewcode);
  assign w_set_attempt = r_chk_set;
  assign w_code        = r_code;
`else
  assign w_set         = 1'b0;
  assign w_in_newcode  = 1'b0;
  assign w_set_attempt = 1'b0;
  assign w_code        = DEFAULT_CODE[BufW-1:0];
`endif

  always_comb begin
    w_state_d  = r_state;
    w_buf_d    = r_buf;
    w_cnt_d    = r_cnt;
    w_ovf_d    = r_ovf;
    w_fail_d   = r_fail;
    w_arm_d    = 1'b0;
    w_disarm_d = 1'b0;
    w_bad_d    = 1'b0;
    w_tmr_load = 1'b0;
    w_tmr_val  = TmrEntry;
    w_tmr_en   = 1'b0;
`ifdef KEYPAD_CODE_CHANGE_EN
    w_code_d    = r_code;
    w_chk_set_d = r_chk_set;
`endif

    case (r_state)
      StIdle: begin
        if (w_digit) begin
          w_buf_d    = w_buf_sh[BufW-1:0];
          w_cnt_d    = CntW'(1);
          w_ovf_d    = 1'b0;
          w_tmr_load = 1'b1;
          w_state_d  = StEntry;
        end
      end

      StEntry
`ifdef KEYPAD_CODE_CHANGE_EN
      , StNewcode
`endif
      : begin
        // Any key restarts the idle timeout, even ignored ones.
        if (key_valid) w_tmr_load = 1'b1;
        else           w_tmr_en   = 1'b1;

        if (w_digit) begin
          if (r_cnt == LenCnt) begin
            w_ovf_d = 1'b1;
          end else begin
            w_buf_d = w_buf_sh[BufW-1:0];
            w_cnt_d = r_cnt + 1'b1;
          end
        end else if (w_clear || (!key_valid && w_tmr_expired)) begin
          w_buf_d   = '0;
          w_cnt_d   = '0;
          w_ovf_d   = 1'b0;
          w_state_d = StIdle;
        end else if (w_enter) begin
          if (w_in_newcode) begin
`ifdef KEYPAD_CODE_CHANGE_EN
            if ((r_cnt == LenCnt) && !r_ovf) w_code_d = r_buf;
`endif
            w_buf_d   = '0;
            w_cnt_d   = '0;
            w_ovf_d   = 1'b0;
            w_state_d = StIdle;
          end else begin
`ifdef KEYPAD_CODE_CHANGE_EN
            w_chk_set_d = 1'b0;
`endif
            w_state_d = StCheck;
          end
        end else if (w_set && !w_in_newcode) begin
`ifdef KEYPAD_CODE_CHANGE_EN
          w_chk_set_d = 1'b1;
`endif
          w_state_d = StCheck;
        end
      end

      StCheck: begin
        w_buf_d = '0;
        w_cnt_d = '0;
        w_ovf_d = 1'b0;
        if (w_match && !w_set_attempt) begin
          w_arm_d    = !armed_in;
          w_disarm_d = armed_in;
          w_fail_d   = '0;
          w_state_d  = StIdle;
        end
`ifdef KEYPAD_CODE_CHANGE_EN
        else if (w_match && !armed_in) begin
          w_tmr_load = 1'b1;
          w_state_d  = StNewcode;
        end
`endif
        else begin
          w_bad_d  = 1'b1;
          w_fail_d = w_fail_inc;
          if (w_fail_inc == FailMax) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = TmrLock;
            w_state_d  = StLockout;
          end else begin
            w_state_d = StIdle;
          end
        end
      end

      StLockout: begin
        if (w_tmr_expired) begin
          w_fail_d  = '0;
          w_state_d = StIdle;
        end else begin
          w_tmr_en = 1'b1;
        end
      end

      default: begin
        w_buf_d   = '0;
        w_cnt_d   = '0;
        w_ovf_d   = 1'b0;
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_buf    <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_fail   <= '0;
      r_arm    <= 1'b0;
      r_disarm <= 1'b0;
      r_bad    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_buf    <= w_buf_d;
      r_cnt    <= w_cnt_d;
      r_ovf    <= w_ovf_d;
      r_fail   <= w_fail_d;
      r_arm    <= w_arm_d;
      r_disarm <= w_disarm_d;
      r_bad    <= w_bad_d;
    end
  end

`ifdef KEYPAD_CODE_CHANGE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_code    <= DEFAULT_CODE[BufW-1:0];
      r_chk_set <= 1'b0;
    end else begin
      r_code    <= w_code_d;
      r_chk_set <= w_chk_set_d;
    end
  end
`endif

  kp_timer #(
    .Width(TmrW)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_en       (w_tmr_en),
    .o_expired  (w_tmr_expired)
  );

  assign cmd_arm     = r_arm;
  assign cmd_disarm  = r_disarm;
  assign bad_code    = r_bad;
  assign lockout     = (r_state == StLockout);
  assign digit_count = r_cnt;
`ifdef KEYPAD_CODE_CHANGE_EN
  assign entry_busy  = (r_state == StEntry) || (r_state == StCheck) || (r_state == StNewcode);
`else
  assign entry_busy  = (r_state == StEntry) || (r_state == StCheck);
`endif

endmodule
